// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the MiniSRC memory-port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int TIMEOUT_CYC_DEF = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic OWN_F = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arb_timer.sv
// Memory-wait counter: clear on grant, count while enabled, flag the increment that reaches TERM.
module mem_arb_timer #(
    parameter int TERM = 255
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iClr,
    input  logic iEn,
    output logic oTc
);

    localparam int CNT_W = $clog2(TERM + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // oTc marks the cycle whose increment would bring the count to TERM
    assign oTc = iEn && (cnt_q == CNT_W'(TERM - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (iClr) begin
            cnt_d = '0;
        end else if (iEn) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fixed-priority (data over fetch) arbiter for the single MiniSRC memory port.
// Optional memory-wait abort enabled by defining MEM_PORT_ARBITER_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iF_Req,
    input  logic [ADDR_W-1:0] iF_Addr,
    output logic              oF_Done,
    output logic [DATA_W-1:0] oF_Data,
    input  logic              iD_Req,
    input  logic              iD_Wr,
    input  logic [ADDR_W-1:0] iD_Addr,
    input  logic [DATA_W-1:0] iD_WrData,
    output logic              oD_Done,
    output logic [DATA_W-1:0] oD_Data,
    output logic [ADDR_W-1:0] oMem_Addr,
    output logic [DATA_W-1:0] oMem_WrData,
    output logic              oMem_Rd,
    output logic              oMem_Wr,
    input  logic              iMem_Rdy,
    input  logic [DATA_W-1:0] iMem_RdData,
    output logic              oBusy,
    output logic              oErr
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              f_done_q, f_done_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] f_data_q, f_data_d;
    logic [DATA_W-1:0] d_data_q, d_data_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              grant;
    logic              timeout;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    logic tmr_en;
    assign tmr_en = (state_q == BUSY) && !iMem_Rdy;

    mem_arb_timer #(
        .TERM (TIMEOUT_CYC)
    ) u_timer (
        .iClk (iClk),
        .iRst (iRst),
        .iClr (grant),
        .iEn  (tmr_en),
        .oTc  (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        f_done_d = 1'b0;
        d_done_d = 1'b0;
        f_data_d = f_data_q;
        d_data_d = d_data_q;
        err_d    = err_q | timeout;
        grant    = 1'b0;

        case (state_q)
            IDLE: begin
                if (iD_Req) begin
                    grant   = 1'b1;
                    owner_d = OWN_D;
                    addr_d  = iD_Addr;
                    wdata_d = iD_WrData;
                    wr_d    = iD_Wr;
                    rd_d    = !iD_Wr;
                    state_d = BUSY;
                end else if (iF_Req) begin
                    grant   = 1'b1;
                    owner_d = OWN_F;
                    addr_d  = iF_Addr;
                    wr_d    = 1'b0;
                    rd_d    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (iMem_Rdy) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = RESP;
                    // wr_q still reflects the granted access while in BUSY
                    if (!wr_q) begin
                        if (owner_q == OWN_D) begin
                            d_data_d = iMem_RdData;
                        end else begin
                            f_data_d = iMem_RdData;
                        end
                    end
                end else if (timeout) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (owner_q == OWN_D) begin
                    d_done_d = 1'b1;
                end else begin
                    f_done_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= IDLE;
            owner_q  <= OWN_F;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            f_done_q <= 1'b0;
            d_done_q <= 1'b0;
            f_data_q <= '0;
            d_data_q <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            f_done_q <= f_done_d;
            d_done_q <= d_done_d;
            f_data_q <= f_data_d;
            d_data_q <= d_data_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign oMem_Addr   = addr_q;
    assign oMem_WrData = wdata_q;
    assign oMem_Rd     = rd_q;
    assign oMem_Wr     = wr_q;
    assign oF_Done     = f_done_q;
    assign oD_Done     = d_done_q;
    assign oF_Data     = f_data_q;
    assign oD_Data     = d_data_q;
    assign oBusy       = busy_q;
    assign oErr        = err_q;

endmodule
